execute_redirect_ctrl: RTL
==========================

// Module: execute_redirect_ctrl
// PURPOSE
//  Parametrised execute-to-hazard control block: arbitrates NUM_SRC redirect requests (exception, mispredict, fence, ...).
//  Issues a timed multi-cycle flush, then holds a redirect to fetch until fetch accepts it.
//  Folds data-memory wait into the pipeline stall.
//  Sits between execute/writeback redirect sources and the fetch stage / pipeline latches.
// PARAMETERS
//  NUM_SRC       3   number of redirect sources; index 0 = highest priority
//  ADDR_W        32  redirect target address width
//  FLUSH_CYCLES  2   cycles flush is held per redirect; legal range 1..15
// PORTS
//  CLK             in   1               clock, all logic rising-edge
//  RST             in   1               synchronous reset, active high
//  req_valid       in   NUM_SRC         per-source redirect request
//  req_addr        in   NUM_SRC*ADDR_W  per-source target; source i at [i*ADDR_W +: ADDR_W]
//  dwait           in   1               data memory not ready
//  fetch_ready     in   1               fetch accepts redirect this cycle
//  flush           out  1               squash younger pipeline latches
//  stall           out  1               freeze pipeline latches
//  redirect_valid  out  1               redirect_addr is valid for fetch
//  redirect_addr   out  ADDR_W          captured target address
//  redirect_src    out  $clog2(NUM_SRC) index of winning source; width min 1
//  busy            out  1               FSM not in IDLE
// BEHAVIOUR
//  Reset: synchronous, active high; takes effect on next edge even mid-flush/mid-redirect.
//   State=IDLE, counter=0, all outputs 0, captured addr/src=0.
//  Arbitration: fixed priority, lowest index wins. Winner addr/src registered; visible the cycle after request.
//  FSM states IDLE, FLUSH, REDIRECT:
//   IDLE: any req_valid -> capture winner, cnt=FLUSH_CYCLES-1, go FLUSH.
//    Else flush=0, redirect_valid=0, stall=dwait.
//   FLUSH: flush=1, stall=0 (flush dominates dwait), redirect_valid=0.
//    cnt==0 -> REDIRECT, else cnt-1.
//   REDIRECT: redirect_valid=1, stall=1, flush=0.
//    fetch_ready=1 -> handshake done -> IDLE.
//  Preemption (FLUSH or REDIRECT): req from source index < captured src -> recapture, reload cnt, go FLUSH.
//   Requests of equal/lower priority are dropped; those sources are being squashed.
//  Simultaneous handshake + request in REDIRECT: handshake completes.
//   Any new req (any index) captured and FSM goes FLUSH directly, no IDLE cycle.
//  Preemption vs handshake same cycle: preemption wins; handshake discarded, redirect_valid drops next cycle.
//  Latency: request at cycle t -> flush cycles t+1..t+FLUSH_CYCLES -> redirect_valid from t+FLUSH_CYCLES+1.
//  redirect_addr/redirect_src stable while redirect_valid=1 unless preempted.
//  busy = (state != IDLE). Counter is 4 bits; FLUSH_CYCLES outside 1..15 is an elaboration error.
// CONFIGURATION
//  REDIRECT_STATS_EN defined: extra outputs redirect_count[31:0], preempt_count[15:0].
//   redirect_count +1 per completed handshake; preempt_count +1 per preemption.
//   Both saturate at all-ones, clear on RST.
//  REDIRECT_STATS_EN undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1. Reset/idle: RST=1 for 2 cycles while req_valid=3'b111 -> all outputs 0; busy=0.
//     dwait=1 in IDLE -> stall=1, flush=0.
//  2. Single redirect: FLUSH_CYCLES=2; req_valid=3'b100, addr2=0x0000_0400 at t0.
//     -> flush=1 at t1,t2; redirect_valid=1 from t3 with addr=0x400, src=2.
//     fetch_ready at t5 -> IDLE at t6.
//  3. Preemption: src2 redirect in FLUSH; src0 request, addr=0x0000_0100.
//     -> flush restarts for 2 cycles; redirect_addr=0x100, src=0.
//     Later src1 request during REDIRECT is ignored.
//  4. Back-to-back: fetch_ready=1 and req_valid=3'b010 same cycle in REDIRECT.
//     -> next cycle FLUSH with src=1, busy never drops.
//  5. Reset mid-op: RST asserted in REDIRECT -> next cycle IDLE, redirect_valid=0, flush=0.
//  6. REDIRECT_STATS_EN: 3 completed redirects plus 1 preemption -> redirect_count=3, preempt_count=1.
//     preset redirect_count=32'hFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/execute_redirect_ctrl.sv
// Execute-stage redirect controller: fixed-priority arbitration of redirect sources,
// timed flush, redirect hold until fetch accepts. Optional stats via REDIRECT_STATS_EN.
module execute_redirect_ctrl #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  localparam int unsigned SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_SRC-1:0]          req_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   req_addr,
  input  logic                        dwait,
  input  logic                        fetch_ready,
  output logic                        flush,
  output logic                        stall,
  output logic                        redirect_valid,
  output logic [ADDR_W-1:0]           redirect_addr,
  output logic [SRC_W-1:0]            redirect_src,
`ifdef REDIRECT_STATS_EN
  output logic [31:0]                 redirect_count,
  output logic [15:0]                 preempt_count,
`endif
  output logic                        busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..15");
  end

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SRC_W-1:0]  src_q, src_d;

  logic              win_valid;
  logic [SRC_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              preempt;

  // Fixed priority: scan from the top so the lowest requesting index is left standing.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_valid = 1'b1;
        win_idx   = SRC_W'(i);
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign preempt = (state_q != ST_IDLE) && win_valid && (win_idx < src_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    src_d   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          addr_d  = win_addr;
          src_d   = win_idx;
        end
      end
      ST_FLUSH: begin
        if (preempt) begin
          cnt_d  = CNT_W'(FLUSH_CYCLES - 1);
          addr_d = win_addr;
          src_d  = win_idx;
        end else if (cnt_q == '0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        // Preemption overrides a same-cycle handshake; a plain handshake may chain straight into a new flush.
        if (preempt || (fetch_ready && win_valid)) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          addr_d  = win_addr;
          src_d   = win_idx;
        end else if (fetch_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
    end
  end

  assign flush          = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign stall          = (state_q == ST_REDIRECT) || ((state_q == ST_IDLE) && dwait);
  assign busy           = (state_q != ST_IDLE);
  assign redirect_addr  = addr_q;
  assign redirect_src   = src_q;

`ifdef REDIRECT_STATS_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [15:0] preempt_count_q, preempt_count_d;
  logic        hs_done;

  assign hs_done = (state_q == ST_REDIRECT) && fetch_ready && !preempt;

  // Saturating event counters.
  always_comb begin
    redirect_count_d = redirect_count_q;
    preempt_count_d  = preempt_count_q;
    if (hs_done && (redirect_count_q != '1)) redirect_count_d = redirect_count_q + 32'd1;
    if (preempt && (preempt_count_q != '1))  preempt_count_d  = preempt_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      redirect_count_q <= '0;
      preempt_count_q  <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      preempt_count_q  <= preempt_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign preempt_count  = preempt_count_q;
`endif

endmodule
